// File: rtl/display_control_pkg.sv
// Shared game definitions: display FSM states, game status codes and colours.
package display_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ERASE,
        ST_DRAW,
        ST_END_FILL,
        ST_END_HOLD
    } state_t;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_END  = 2'b10;

    localparam logic [2:0] COLOUR_BG    = 3'b000;
    localparam logic [2:0] COLOUR_BLOCK = 3'b110;
    localparam logic [2:0] COLOUR_END   = 3'b100;

    // States that walk a rectangle and emit one pixel per cycle.
    function automatic logic is_pass(input state_t s);
        return (s == ST_CLEAR) || (s == ST_ERASE) || (s == ST_DRAW) || (s == ST_END_FILL);
    endfunction

endpackage

// File: rtl/display_control_rect_scanner.sv
// Row-major rectangle walker: column inner, row outer, with a done pulse on the last pixel.
// The next offsets are exposed so the owner can register pixel outputs in step with them.
module rect_scanner (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] next_col,
    output logic [6:0] next_row,
    output logic       done
);
    logic [7:0] col;
    logic [6:0] row;
    logic       last_col;
    logic       last_row;

    // Next offset: start restarts at the origin and overrides a concurrent step.
    always_comb begin
        last_col = (col == width - 8'd1);
        last_row = (row == height - 7'd1);
        done     = step && last_col && last_row;
        next_col = col;
        next_row = row;
        if (start) begin
            next_col = '0;
            next_row = '0;
        end else if (step) begin
            if (last_col) begin
                next_col = '0;
                next_row = last_row ? 7'd0 : row + 7'd1;
            end else begin
                next_col = col + 8'd1;
            end
        end
    end

    // Offset registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= next_col;
            row <= next_row;
        end
    end

endmodule

// File: rtl/display_control.sv
// Display controller: erases/draws the moving block, fills the end screen, clears the screen.
module display_control
    import display_control_pkg::*;
#(
    parameter int BLOCK_W = 16,
    parameter int BLOCK_H = 4,
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_status,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic       frame_tick,
    input  logic       commit,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy
);
    localparam logic [7:0] BLK_W8 = 8'(BLOCK_W);
    localparam logic [6:0] BLK_H7 = 7'(BLOCK_H);
    localparam logic [7:0] SCR_W8 = 8'(SCR_W);
    localparam logic [6:0] SCR_H7 = 7'(SCR_H);
    localparam logic [8:0] SCR_W9 = 9'(SCR_W);
    localparam logic [7:0] SCR_H8 = 8'(SCR_H);

    state_t     state, next_state;
    logic [7:0] cur_x, prev_x, cur_x_next, base_x;
    logic [6:0] cur_y, prev_y, cur_y_next, base_y;
    logic       skip_erase, clear_pending;
    logic       scan_start, scan_step, scan_done, accept_play;
    logic [7:0] scan_w, next_col;
    logic [6:0] scan_h, next_row;
    logic [8:0] px;
    logic [7:0] py;
    logic [2:0] colour_next;
    logic       pass_next, plot_next;

    rect_scanner u_scanner (
        .clk      (clk),
        .reset    (reset),
        .start    (scan_start),
        .step     (scan_step),
        .width    (scan_w),
        .height   (scan_h),
        .next_col (next_col),
        .next_row (next_row),
        .done     (scan_done)
    );

    assign busy = (state != ST_IDLE);

    // Next state and scanner control; a status change during a pass waits until IDLE.
    always_comb begin
        next_state  = state;
        scan_start  = 1'b0;
        scan_step   = 1'b0;
        accept_play = 1'b0;
        scan_w      = SCR_W8;
        scan_h      = SCR_H7;
        if (state == ST_ERASE || state == ST_DRAW) begin
            scan_w = BLK_W8;
            scan_h = BLK_H7;
        end
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    if (game_status == GS_PLAY) begin
                        accept_play = 1'b1;
                        scan_start  = 1'b1;
                        next_state  = (skip_erase || commit) ? ST_DRAW : ST_ERASE;
                    end else if (game_status == GS_END) begin
                        scan_start = 1'b1;
                        next_state = ST_END_FILL;
                    end else if (clear_pending) begin
                        scan_start = 1'b1;
                        next_state = ST_CLEAR;
                    end
                end
            end
            ST_ERASE: begin
                scan_step = 1'b1;
                if (scan_done) begin
                    scan_start = 1'b1;
                    next_state = ST_DRAW;
                end
            end
            ST_DRAW: begin
                scan_step = 1'b1;
                if (scan_done) next_state = ST_IDLE;
            end
            ST_END_FILL: begin
                scan_step = 1'b1;
                if (scan_done) next_state = ST_END_HOLD;
            end
            ST_CLEAR: begin
                scan_step = 1'b1;
                if (scan_done) next_state = ST_IDLE;
            end
            ST_END_HOLD: begin
                if (game_status != GS_END) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Pixel for the coming cycle, built from next state and next offsets so outputs stay aligned.
    always_comb begin
        cur_x_next  = accept_play ? x_in : cur_x;
        cur_y_next  = accept_play ? y_in : cur_y;
        base_x      = '0;
        base_y      = '0;
        colour_next = COLOUR_BG;
        case (next_state)
            ST_ERASE: begin
                base_x = prev_x;
                base_y = prev_y;
            end
            ST_DRAW: begin
                base_x      = cur_x_next;
                base_y      = cur_y_next;
                colour_next = COLOUR_BLOCK;
            end
            ST_END_FILL: colour_next = COLOUR_END;
            default: colour_next = COLOUR_BG;
        endcase
        // Widened sums so blocks near the right/bottom edge clip instead of wrapping.
        px        = {1'b0, base_x} + {1'b0, next_col};
        py        = {1'b0, base_y} + {1'b0, next_row};
        pass_next = is_pass(next_state);
        plot_next = pass_next && (px < SCR_W9) && (py < SCR_H8);
    end

    // State, block positions, sticky flags and registered VGA outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cur_x         <= '0;
            cur_y         <= '0;
            prev_x        <= '0;
            prev_y        <= '0;
            skip_erase    <= 1'b1;
            clear_pending <= 1'b1;
            plot          <= 1'b0;
            vga_x         <= '0;
            vga_y         <= '0;
            colour        <= COLOUR_BG;
        end else begin
            state <= next_state;
            cur_x <= cur_x_next;
            cur_y <= cur_y_next;
            if (state == ST_DRAW && scan_done) begin
                prev_x <= cur_x;
                prev_y <= cur_y;
            end
            // The flag is consumed when a play frame starts; commits during the frame arm the next one.
            if (state == ST_END_HOLD && next_state == ST_IDLE) begin
                skip_erase    <= 1'b1;
                clear_pending <= 1'b1;
            end else begin
                if (accept_play) skip_erase <= 1'b0;
                else if (commit) skip_erase <= 1'b1;
                if (state == ST_CLEAR && scan_done) clear_pending <= 1'b0;
            end
            plot <= plot_next;
            if (pass_next) begin
                vga_x  <= px[7:0];
                vga_y  <= py[6:0];
                colour <= colour_next;
            end
        end
    end

endmodule

// File: tb/tb_display_control.sv
// Directed bench for display_control: reset, clear, block frames, clipping, commit, end screen.
module tb_display_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] game_status;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       frame_tick;
    logic       commit;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy;
    int bad;

    logic       cap_plot[$];
    logic [7:0] cap_x[$];
    logic [6:0] cap_y[$];
    logic [2:0] cap_c[$];

    display_control dut (
        .clk         (clk),
        .reset       (reset),
        .game_status (game_status),
        .x_in        (x_in),
        .y_in        (y_in),
        .frame_tick  (frame_tick),
        .commit      (commit),
        .plot        (plot),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .colour      (colour),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        next_cycle();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        next_cycle();
        commit = 1'b0;
    endtask

    // Record one entry per busy cycle; optional injection at cycle inj_at:
    // kind 1 = frame_tick with x_in=0, kind 2 = commit, kind 3 = game_status <= 10.
    task automatic capture(input int limit, input int inj_at, input int kind);
        cap_plot.delete();
        cap_x.delete();
        cap_y.delete();
        cap_c.delete();
        n_busy = 0;
        for (int k = 0; k < limit; k++) begin
            if (busy !== 1'b1) break;
            cap_plot.push_back(plot);
            cap_x.push_back(vga_x);
            cap_y.push_back(vga_y);
            cap_c.push_back(colour);
            n_busy++;
            if (k == inj_at) begin
                if (kind == 1) begin
                    frame_tick = 1'b1;
                    x_in = 8'd0;
                end
                if (kind == 2) commit = 1'b1;
                if (kind == 3) game_status = 2'b10;
            end
            next_cycle();
            frame_tick = 1'b0;
            commit = 1'b0;
        end
    endtask

    // Number of recorded cycles disagreeing with a row-major w x h walk from (bx,by).
    function automatic int rect_bad(input int first, input int bx, input int by,
                                    input logic [2:0] c, input int w, input int h);
        int cnt = 0;
        for (int i = 0; i < w * h; i++) begin
            int ex;
            int ey;
            logic ep;
            ex = bx + i % w;
            ey = by + i / w;
            ep = (ex < 160) && (ey < 120);
            if (first + i >= cap_plot.size()) cnt++;
            else if (cap_plot[first + i] !== ep) cnt++;
            else if (ep && (cap_x[first + i] !== 8'(ex) || cap_y[first + i] !== 7'(ey) ||
                            cap_c[first + i] !== c)) cnt++;
        end
        return cnt;
    endfunction

    function automatic int plot_count();
        int cnt = 0;
        foreach (cap_plot[i]) if (cap_plot[i] === 1'b1) cnt++;
        return cnt;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) next_cycle();
        n_checks++;
        if ({plot, vga_x, vga_y, colour, busy} !== 20'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got plot=%b x=%0d y=%0d colour=%b busy=%b, want all zero",
                     plot, vga_x, vga_y, colour, busy);
        end
        reset = 1'b0;
        next_cycle();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_without_tick: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_clear();
        game_status = 2'b00;
        pulse_tick();
        capture(20000, -1, 0);
        n_checks++;
        if (n_busy != 19200) begin
            n_errors++;
            $display("FAIL clear_cycles: got %0d, want 19200", n_busy);
        end
        bad = rect_bad(0, 0, 0, 3'b000, 160, 120);
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL clear_pixels: %0d wrong pixels, want 0", bad);
        end
        pulse_tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_not_repeated: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_first_draw();
        game_status = 2'b01;
        x_in = 8'd40;
        y_in = 7'd100;
        pulse_tick();
        n_checks++;
        if (plot !== 1'b1 || vga_x !== 8'd40 || vga_y !== 7'd100) begin
            n_errors++;
            $display("FAIL first_plot_latency: plot=%b x=%0d y=%0d, want 1 40 100", plot, vga_x, vga_y);
        end
        capture(300, -1, 0);
        n_checks++;
        if (n_busy != 64) begin
            n_errors++;
            $display("FAIL first_draw_cycles: got %0d, want 64", n_busy);
        end
        bad = rect_bad(0, 40, 100, 3'b110, 16, 4);
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL first_draw_pixels: %0d wrong, want 0", bad);
        end
    endtask

    task automatic test_erase_draw();
        x_in = 8'd42;
        pulse_tick();
        capture(300, -1, 0);
        n_checks++;
        if (n_busy != 128) begin
            n_errors++;
            $display("FAIL erase_draw_cycles: got %0d, want 128", n_busy);
        end
        bad = rect_bad(0, 40, 100, 3'b000, 16, 4) + rect_bad(64, 42, 100, 3'b110, 16, 4);
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL erase_draw_pixels: %0d wrong, want 0", bad);
        end
    endtask

    task automatic test_commit();
        pulse_commit();
        y_in = 7'd96;
        pulse_tick();
        capture(300, -1, 0);
        bad = rect_bad(0, 42, 96, 3'b110, 16, 4);
        n_checks++;
        if (n_busy != 64 || bad != 0) begin
            n_errors++;
            $display("FAIL commit_skip_erase: cycles=%0d wrong=%0d, want 64 and 0", n_busy, bad);
        end
    endtask

    task automatic test_clip();
        pulse_commit();
        x_in = 8'd150;
        pulse_tick();
        capture(300, 20, 1);
        n_checks++;
        if (n_busy != 64 || plot_count() != 40) begin
            n_errors++;
            $display("FAIL clip_draw: cycles=%0d plots=%0d, want 64 and 40", n_busy, plot_count());
        end
        bad = rect_bad(0, 150, 96, 3'b110, 16, 4);
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL clip_draw_pixels: %0d wrong, want 0", bad);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL tick_while_busy_dropped: busy=%b, want 0", busy);
        end
        x_in = 8'd10;
        y_in = 7'd20;
        pulse_tick();
        capture(300, -1, 0);
        bad = rect_bad(0, 150, 96, 3'b000, 16, 4) + rect_bad(64, 10, 20, 3'b110, 16, 4);
        n_checks++;
        if (n_busy != 128 || plot_count() != 104 || bad != 0) begin
            n_errors++;
            $display("FAIL clip_erase: cycles=%0d plots=%0d wrong=%0d, want 128 104 0",
                     n_busy, plot_count(), bad);
        end
    endtask

    task automatic test_commit_at_erase_end();
        x_in = 8'd30;
        pulse_tick();
        capture(300, 63, 2);
        n_checks++;
        if (n_busy != 128) begin
            n_errors++;
            $display("FAIL commit_erase_end_frame: cycles=%0d, want 128", n_busy);
        end
        x_in = 8'd60;
        y_in = 7'd40;
        pulse_tick();
        capture(300, 10, 3);
        bad = rect_bad(0, 60, 40, 3'b110, 16, 4);
        n_checks++;
        if (n_busy != 64 || bad != 0) begin
            n_errors++;
            $display("FAIL commit_erase_end_next: cycles=%0d wrong=%0d, want 64 and 0", n_busy, bad);
        end
    endtask

    task automatic test_end_screen();
        pulse_tick();
        capture(19200, -1, 0);
        bad = rect_bad(0, 0, 0, 3'b100, 160, 120);
        n_checks++;
        if (n_busy != 19200 || bad != 0) begin
            n_errors++;
            $display("FAIL end_fill: cycles=%0d wrong=%0d, want 19200 and 0", n_busy, bad);
        end
        repeat (5) next_cycle();
        n_checks++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            n_errors++;
            $display("FAIL end_hold: busy=%b plot=%b, want 1 0", busy, plot);
        end
        game_status = 2'b01;
        next_cycle();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL end_hold_exit: busy=%b, want 0", busy);
        end
        game_status = 2'b00;
        pulse_tick();
        capture(20000, -1, 0);
        n_checks++;
        if (n_busy != 19200 || plot_count() != 19200) begin
            n_errors++;
            $display("FAIL clear_after_end: cycles=%0d plots=%0d, want 19200 19200", n_busy, plot_count());
        end
        game_status = 2'b01;
        x_in = 8'd0;
        y_in = 7'd0;
        pulse_tick();
        capture(300, -1, 0);
        n_checks++;
        if (n_busy != 64) begin
            n_errors++;
            $display("FAIL skip_after_end: cycles=%0d, want 64", n_busy);
        end
    endtask

    task automatic test_reset_mid();
        int plots;
        x_in = 8'd5;
        y_in = 7'd5;
        pulse_tick();
        repeat (10) next_cycle();
        reset = 1'b1;
        next_cycle();
        n_checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_op: plot=%b busy=%b, want 0 0", plot, busy);
        end
        next_cycle();
        reset = 1'b0;
        plots = 0;
        for (int i = 0; i < 20; i++) begin
            if (plot !== 1'b0) plots++;
            next_cycle();
        end
        n_checks++;
        if (plots != 0) begin
            n_errors++;
            $display("FAIL reset_no_plots: got %0d plots, want 0", plots);
        end
        game_status = 2'b11;
        pulse_tick();
        n_checks++;
        if (busy !== 1'b1 || plot !== 1'b1 || colour !== 3'b000) begin
            n_errors++;
            $display("FAIL status11_clear: busy=%b plot=%b colour=%b, want 1 1 000", busy, plot, colour);
        end
        reset = 1'b1;
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        game_status = 2'b00;
        x_in = 8'd0;
        y_in = 7'd0;
        frame_tick = 1'b0;
        commit = 1'b0;
        test_reset();
        test_clear();
        test_first_draw();
        test_erase_draw();
        test_commit();
        test_clip();
        test_commit_at_erase_end();
        test_end_screen();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
